// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative restoring divider.
// Holds the FSM state encoding and the default operand width.
package seq_divider_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] pr,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] pr_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;
    logic [WIDTH:0] diff;

    // The partial remainder is WIDTH+1 bits wide only transiently; after the
    // restore it is below the divisor, and with a zero divisor the dropped
    // top bit would be shifted out on the next step anyway.
    always_comb begin
        shifted = {pr, dvd_bit};
        dvs_ext = {1'b0, divisor};
        diff    = shifted - dvs_ext;
        q_bit   = (shifted >= dvs_ext);
        pr_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DBZ_EN to short-circuit a zero divisor and flag dbz.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               dbz
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   shreg;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] pr_step;
    logic [CW-1:0]   cnt;
    logic            q_bit;
    logic            dbz_q;
    logic            accept;
    logic            fast;

`ifdef SEQ_DIVIDER_DBZ_EN
    assign fast = (divisor == '0);
`else
    assign fast = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .pr      (pr),
        .dvd_bit (shreg[DW-1]),
        .divisor (dvs),
        .pr_next (pr_step),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = fast ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Dividend bits leave at the top of shreg while quotient bits enter at
    // the bottom, so after the last step shreg holds the full quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            dvs   <= '0;
            pr    <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            dvs <= divisor;
            cnt <= CW'(DW - 1);
            if (fast) begin
                shreg <= '1;
                pr    <= dividend[WIDTH-1:0];
                dbz_q <= 1'b1;
            end else begin
                shreg <= dividend;
                pr    <= '0;
                dbz_q <= 1'b0;
            end
        end else if (state == RUN) begin
            shreg <= {shreg[DW-2:0], q_bit};
            pr    <= pr_step;
            cnt   <= cnt - 1'b1;
        end
    end

    assign quotient  = shreg;
    assign remainder = pr;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases, reset abort,
// backpressure and randomized operations against a behavioural model.
module tb_seq_divider;

    localparam int W  = 4;
    localparam int DW = 2 * W;
`ifdef SEQ_DIVIDER_DBZ_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          dbz;

    int total = 0;
    int bad = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: busy/valid timing plus arithmetic results.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    bit [DW-1:0] exp_q = '0;
    bit [W-1:0]  exp_r = '0;
    bit          exp_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (!m_busy && in_valid) begin
            m_busy <= 1'b1;
            if (divisor == 0) begin
                exp_q <= {DW{1'b1}};
                exp_r <= dividend[W-1:0];
            end else begin
                exp_q <= dividend / DW'(divisor);
                exp_r <= W'(dividend % DW'(divisor));
            end
            if (DBZ_EN && divisor == 0) begin
                m_valid <= 1'b1;
                exp_dbz <= 1'b1;
            end else begin
                m_left  <= DW;
                exp_dbz <= 1'b0;
            end
        end else if (m_busy && !m_valid) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_valid <= 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(!m_busy));
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid && out_valid) begin
            chk("quotient", int'(quotient), int'(exp_q));
            chk("remainder", int'(remainder), int'(exp_r));
            chk("dbz", int'(dbz), int'(exp_dbz));
        end
    end

    task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit lit,
                          input int eq, input int er, input int edbz,
                          input int elat);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("done_timeout", n, -1);
            return;
        end
        if (lit) begin
            chk("lit_latency", n, elat);
            chk("lit_quotient", int'(quotient), eq);
            chk("lit_remainder", int'(remainder), er);
            chk("lit_dbz", int'(dbz), edbz);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            dividend = DW'($urandom);
            divisor  = W'($urandom);
            @(posedge clk); #1;
            if (lit) begin
                chk("hold_in_ready", int'(in_ready), 0);
                chk("hold_quotient", int'(quotient), eq);
                chk("hold_remainder", int'(remainder), er);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(dbz), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'd50, 4'd5, 0, 1'b1, 10, 0, 0, DW);
        run_op(8'd200, 4'd7, 5, 1'b1, 28, 4, 0, DW);
        run_op(8'd255, 4'd1, 0, 1'b1, 255, 0, 0, DW);
        run_op(8'd0, 4'd15, 0, 1'b1, 0, 0, 0, DW);
        run_op(8'hA5, 4'd0, 2, 1'b1, 255, 5, int'(DBZ_EN),
               DBZ_EN ? 0 : DW);

        // Abort mid-RUN with an asynchronous reset.
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = 8'd123;
        divisor  = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(dbz), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op(8'd91, 4'd9, 0, 1'b1, 10, 1, 0, DW);

        for (int k = 0; k < 150; k++) begin
            run_op(DW'($urandom), W'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b0, 0, 0, 0, 0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
